// File: rtl/lane_gene_streamer.sv
// lane_gene_streamer: transmit end of the lane gene-stream interface.
// Reads one genome from a single-port synchronous memory. Node genes come first, then
// connection genes. It drives the lane inputs one gene per cycle, and owns the per-gene
// LFSR that feeds `random`.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   start              begin one genome; sampled in idle only
//   node_cnt, conn_cnt gene counts, latched on accepted start
//   stall              downstream backpressure; blocks new reads
//   mem_rd_en/mem_addr memory read strobe and address (data returns one cycle later)
//   mem_rd_data        memory read data
//   state              lane tag: 00 node gene, 10 connection gene, 01 bubble
//   gene_out, random   gene and its random value for the lane
//   busy, done         busy from accepted start until done; done is a one-cycle pulse
//   chksum             XOR of the genes emitted in the current genome
//                      (only present when LANE_STREAM_CHKSUM_EN is defined)
module lane_gene_streamer #(
  parameter int unsigned GENE_SZ   = 64,
  parameter int unsigned ATTR_SZ   = 8,
  parameter int unsigned ADDR_SZ   = 8,
  parameter int unsigned GAP_CYC   = 1,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_SZ-1:0] node_cnt,
  input  logic [ADDR_SZ-1:0] conn_cnt,
  input  logic               stall,
  output logic               mem_rd_en,
  output logic [ADDR_SZ-1:0] mem_addr,
  input  logic [GENE_SZ-1:0] mem_rd_data,
  output logic [1:0]         state,
  output logic [GENE_SZ-1:0] gene_out,
  output logic [ATTR_SZ-1:0] random,
  output logic               busy,
  output logic               done
`ifdef LANE_STREAM_CHKSUM_EN
  ,
  output logic [GENE_SZ-1:0] chksum
`endif
);

  localparam logic [7:0] Seed    = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [3:0] GapLast = 4'(GAP_CYC - 1);

  typedef enum logic [2:0] {StIdle, StNode, StGap, StConn, StDrain, StFin} st_e;

  st_e                st_q, st_d;
  logic [ADDR_SZ-1:0] idx_q, idx_d;
  logic [ADDR_SZ-1:0] node_q, node_d;
  logic [ADDR_SZ-1:0] conn_q, conn_d;
  logic [3:0]         gap_q, gap_d;

  logic               rd_v_q;     // read issued last cycle; data lands this cycle
  logic               rd_conn_q;  // that read belongs to the connection phase
  logic [1:0]         state_q;
  logic [GENE_SZ-1:0] gene_q;
  logic [7:0]         lfsr_q;
  logic [7:0]         lfsr_next;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= StIdle;
      idx_q  <= '0;
      node_q <= '0;
      conn_q <= '0;
      gap_q  <= '0;
    end else begin
      st_q   <= st_d;
      idx_q  <= idx_d;
      node_q <= node_d;
      conn_q <= conn_d;
      gap_q  <= gap_d;
    end
  end

  // Next-state logic
  always_comb begin
    st_d   = st_q;
    idx_d  = idx_q;
    node_d = node_q;
    conn_d = conn_q;
    gap_d  = gap_q;
    unique case (st_q)
      StIdle: begin
        if (start) begin
          node_d = node_cnt;
          conn_d = conn_cnt;
          idx_d  = '0;
          gap_d  = '0;
          st_d   = (node_cnt != '0) ? StNode : StGap;
        end
      end
      StNode: begin
        if (!stall) begin
          if (idx_q == node_q - ADDR_SZ'(1)) begin
            idx_d = '0;
            st_d  = StGap;
          end else begin
            idx_d = idx_q + ADDR_SZ'(1);
          end
        end
      end
      // No reads while here, so exactly GAP_CYC bubbles separate the two phases.
      StGap: begin
        if (gap_q == GapLast) begin
          gap_d = '0;
          st_d  = (conn_q != '0) ? StConn : StDrain;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      StConn: begin
        if (!stall) begin
          if (idx_q == conn_q - ADDR_SZ'(1)) begin
            idx_d = '0;
            st_d  = StDrain;
          end else begin
            idx_d = idx_q + ADDR_SZ'(1);
          end
        end
      end
      StDrain: begin
        if (!rd_v_q) st_d = StFin;
      end
      StFin:   st_d = StIdle;
      default: st_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (st_q)
      StIdle: busy = 1'b0;
      StNode: begin
        mem_rd_en = !stall;
        mem_addr  = idx_q;
      end
      StConn: begin
        mem_rd_en = !stall;
        mem_addr  = node_q + idx_q;  // wraps modulo 2^ADDR_SZ
      end
      StFin: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign lfsr_next = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);

  // Emit pipeline: read at t, data at t+1, registered onto the lane at the t+2 edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v_q    <= 1'b0;
      rd_conn_q <= 1'b0;
      state_q   <= 2'b01;
      gene_q    <= '0;
      lfsr_q    <= Seed;
    end else begin
      rd_v_q    <= mem_rd_en;
      rd_conn_q <= (st_q == StConn);
      if (rd_v_q) begin
        gene_q  <= mem_rd_data;
        state_q <= rd_conn_q ? 2'b10 : 2'b00;
      end else begin
        gene_q  <= '0;
        state_q <= 2'b01;
      end
      // The current value goes out with the gene, then advances for the next one.
      if (!state_q[0]) lfsr_q <= lfsr_next;
    end
  end

  assign state    = state_q;
  assign gene_out = gene_q;
  assign random   = ATTR_SZ'(lfsr_q);

`ifdef LANE_STREAM_CHKSUM_EN
  logic [GENE_SZ-1:0] chk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_q <= '0;
    end else if (st_q == StIdle && start) begin
      chk_q <= '0;
    end else if (rd_v_q) begin
      chk_q <= chk_q ^ mem_rd_data;
    end
  end

  assign chksum = chk_q;
`endif

endmodule

// File: tb/tb_lane_gene_streamer.sv
// Directed bench for lane_gene_streamer: reset values, basic stream, latency, stall,
// empty phases, mid-stream reset and the LFSR sequence.
module tb_lane_gene_streamer;

  localparam logic [63:0] N0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] N1 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] N2 = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] C0 = 64'hC0C0_0000_1234_5678;
  localparam logic [63:0] C1 = 64'h0000_C1C1_8765_4321;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  node_cnt, conn_cnt;
  logic        stall;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [63:0] mem_rd_data;
  logic [1:0]  state;
  logic [63:0] gene_out;
  logic [7:0]  random;
  logic        busy, done;
`ifdef LANE_STREAM_CHKSUM_EN
  logic [63:0] chksum, chksum0;
`endif

  // Second instance only to observe the zero-seed substitution.
  logic        rd_en0, busy0, done0;
  logic [7:0]  addr0, random0;
  logic [1:0]  state0;
  logic [63:0] gene0;

  logic [63:0] mem [256];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int base = 0;
  bit mon_en = 1'b0;
  bit done_seen;
  int done_cyc;
  logic done_busy;
  logic [63:0] done_chk;
  logic [7:0] exp_lfsr;

  int          a_addr[$], a_rcyc[$], a_state[$], a_gcyc[$];
  logic [63:0] a_gene[$], a_rand[$];
  int          e_addr[$], e_rcyc[$], e_state[$], e_gcyc[$];
  logic [63:0] e_gene[$];
  int          e_done;

  lane_gene_streamer #(
    .GENE_SZ(64), .ATTR_SZ(8), .ADDR_SZ(8), .GAP_CYC(1), .LFSR_SEED(8'hA5)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .node_cnt(node_cnt), .conn_cnt(conn_cnt),
    .stall(stall), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .state(state), .gene_out(gene_out), .random(random), .busy(busy), .done(done)
`ifdef LANE_STREAM_CHKSUM_EN
    , .chksum(chksum)
`endif
  );

  lane_gene_streamer #(
    .GENE_SZ(64), .ATTR_SZ(8), .ADDR_SZ(8), .GAP_CYC(1), .LFSR_SEED(8'h00)
  ) u_dut_seed0 (
    .clk(clk), .rst_n(rst_n), .start(1'b0), .node_cnt(8'd0), .conn_cnt(8'd0),
    .stall(1'b0), .mem_rd_en(rd_en0), .mem_addr(addr0), .mem_rd_data(64'd0),
    .state(state0), .gene_out(gene0), .random(random0), .busy(busy0), .done(done0)
`ifdef LANE_STREAM_CHKSUM_EN
    , .chksum(chksum0)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory: data one cycle after the strobe.
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_rd_en) begin
        a_addr.push_back(int'(mem_addr));
        a_rcyc.push_back(cyc - base);
      end
      if (state != 2'b01) begin
        a_gene.push_back(gene_out);
        a_state.push_back(int'(state));
        a_rand.push_back(64'(random));
        a_gcyc.push_back(cyc - base);
      end
      if (done && !done_seen) begin
        done_seen = 1'b1;
        done_cyc  = cyc - base;
        done_busy = busy;
`ifdef LANE_STREAM_CHKSUM_EN
        done_chk  = chksum;
`else
        done_chk  = '0;
`endif
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    logic [7:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 8'hB8;
    return r;
  endfunction

  task automatic run_genome(input logic [7:0] nc, input logic [7:0] cc,
                            input logic [31:0] smask);
    a_addr.delete(); a_rcyc.delete(); a_state.delete(); a_gcyc.delete();
    a_gene.delete(); a_rand.delete();
    done_seen = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; node_cnt = nc; conn_cnt = cc; base = cyc; stall = smask[0]; mon_en = 1'b1;
    for (int k = 1; k < 32 && !done_seen; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      stall = smask[k];
    end
    stall  = 1'b0;
    mon_en = 1'b0;
  endtask

  task automatic compare_run(input string nm);
    logic [63:0] x;
    x = '0;
    check_eq({nm, " done_seen"}, 64'(done_seen), 64'd1);
    check_eq({nm, " rd_count"}, 64'(a_addr.size()), 64'(e_addr.size()));
    foreach (e_addr[i]) begin
      if (i < a_addr.size()) begin
        check_eq($sformatf("%s addr[%0d]", nm, i), 64'(a_addr[i]), 64'(e_addr[i]));
        check_eq($sformatf("%s rd_cyc[%0d]", nm, i), 64'(a_rcyc[i]), 64'(e_rcyc[i]));
      end
    end
    check_eq({nm, " gene_count"}, 64'(a_gene.size()), 64'(e_gene.size()));
    foreach (e_gene[i]) begin
      if (i < a_gene.size()) begin
        check_eq($sformatf("%s gene[%0d]", nm, i), a_gene[i], e_gene[i]);
        check_eq($sformatf("%s state[%0d]", nm, i), 64'(a_state[i]), 64'(e_state[i]));
        check_eq($sformatf("%s gene_cyc[%0d]", nm, i), 64'(a_gcyc[i]), 64'(e_gcyc[i]));
        check_eq($sformatf("%s random[%0d]", nm, i), a_rand[i], 64'(exp_lfsr));
      end
      exp_lfsr = lfsr_step(exp_lfsr);
      x = x ^ e_gene[i];
    end
    if (done_seen) begin
      check_eq({nm, " done_cyc"}, 64'(done_cyc), 64'(e_done));
      check_eq({nm, " busy_at_done"}, 64'(done_busy), 64'd0);
`ifdef LANE_STREAM_CHKSUM_EN
      check_eq({nm, " chksum"}, done_chk, x);
`endif
    end
  endtask

  task automatic set_basic();
    e_addr  = '{0, 1, 2, 3, 4};
    e_rcyc  = '{1, 2, 3, 5, 6};
    e_gene  = '{N0, N1, N2, C0, C1};
    e_state = '{0, 0, 0, 2, 2};
    e_gcyc  = '{3, 4, 5, 7, 8};
    e_done  = 9;
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 64'(i) * 64'h0101_0101;
    mem[0] = N0; mem[1] = N1; mem[2] = N2; mem[3] = C0; mem[4] = C1;
    mem_rd_data = '0;
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; node_cnt = '0; conn_cnt = '0;
    exp_lfsr = 8'hA5;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst state", 64'(state), 64'(2'b01));
    check_eq("rst gene_out", gene_out, 64'd0);
    check_eq("rst random", 64'(random), 64'hA5);
    check_eq("rst mem_rd_en", 64'(mem_rd_en), 64'd0);
    check_eq("rst mem_addr", 64'(mem_addr), 64'd0);
    check_eq("rst busy", 64'(busy), 64'd0);
    check_eq("rst done", 64'(done), 64'd0);
    check_eq("rst seed0 random", 64'(random0), 64'h01);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("idle state", 64'(state), 64'(2'b01));

    // Basic stream
    set_basic();
    run_genome(8'd3, 8'd2, 32'h0);
    compare_run("basic");

    // Stall on cycles 2..4: read issued in cycle 1 still lands, order unchanged
    set_basic();
    e_rcyc = '{1, 5, 6, 8, 9};
    e_gcyc = '{3, 7, 8, 10, 11};
    e_done = 12;
    run_genome(8'd3, 8'd2, 32'h0000_001C);
    compare_run("stall");

    // No node genes: connection reads start at address 0
    e_addr  = '{0, 1};
    e_rcyc  = '{2, 3};
    e_gene  = '{N0, N1};
    e_state = '{2, 2};
    e_gcyc  = '{4, 5};
    e_done  = 6;
    run_genome(8'd0, 8'd2, 32'h0);
    compare_run("conn_only");

    // Empty genome: done after GAP_CYC+2 cycles, no reads
    e_addr.delete(); e_rcyc.delete(); e_gene.delete(); e_state.delete(); e_gcyc.delete();
    e_done = 3;
    run_genome(8'd0, 8'd0, 32'h0);
    compare_run("empty");

    // Reset during the connection phase
    @(posedge clk); #1;
    start = 1'b1; node_cnt = 8'd3; conn_cnt = 8'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("midrst pre rd_en", 64'(mem_rd_en), 64'd1);
    check_eq("midrst pre addr", 64'(mem_addr), 64'd3);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst state", 64'(state), 64'(2'b01));
    check_eq("midrst busy", 64'(busy), 64'd0);
    check_eq("midrst gene_out", gene_out, 64'd0);
    check_eq("midrst mem_rd_en", 64'(mem_rd_en), 64'd0);
    check_eq("midrst random", 64'(random), 64'hA5);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_lfsr = 8'hA5;
    set_basic();
    run_genome(8'd3, 8'd2, 32'h0);
    compare_run("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
